fb_swap_scheduler: RTL

//  Ping-pong ownership scheduler for the two display frame buffers (buf0/buf1).
//  - Host writes the back buffer; the display timing controller reads the front buffer.
//  - Generates write/read strobes and addresses for both buffers.
//  - Swaps front/back only at a display frame boundary, once the back buffer holds a complete frame.
//  - Sits between the host pixel stream, the buffer RAMs and the display timing controller.

---
 rtl/display_pkg.sv | 17 +
 rtl/fb_addr_counter.sv | 27 ++
 rtl/fb_swap_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display frame-buffer path: scheduler state encoding
// and default geometry of the pixel buffers.
package display_pkg;

    localparam int PIX_W       = 24;
    localparam int ADDR_W      = 10;
    localparam int FRAME_WORDS = 640;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_FULL = 2'd3
    } sched_state_t;

endpackage

// File: rtl/fb_addr_counter.sv
// Buffer address pointer: synchronous clear, increment, wrap to 0 after LIMIT-1.
module fb_addr_counter #(
    parameter int ADDR_W = 10,
    parameter int LIMIT  = 640
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              at_last
);

    assign at_last = (count == ADDR_W'(LIMIT - 1));

    // Clear wins over increment so a frame boundary always restarts at word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= at_last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/fb_swap_scheduler.sv
// Ping-pong ownership scheduler for buf0/buf1: host fills the back buffer, display
// reads the front buffer, and ownership swaps only at a display frame boundary.
//
//  state | meaning
//  IDLE  | chip deselected, display blanked
//  FILL  | first frame going into back buffer, front invalid
//  RUN   | back buffer being written, front valid
//  FULL  | back buffer complete, waiting for disp_frame_end to swap
module fb_swap_scheduler
    import display_pkg::*;
#(
    parameter int PIX_W       = display_pkg::PIX_W,
    parameter int ADDR_W      = display_pkg::ADDR_W,
    parameter int FRAME_WORDS = display_pkg::FRAME_WORDS,
    parameter int CNT_W       = display_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [PIX_W-1:0]  host_data,
    input  logic              host_last,
    input  logic              disp_frame_end,
    input  logic              disp_rd_req,
    output logic              buf0_we,
    output logic              buf1_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              buf0_re,
    output logic              buf1_re,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              front_sel,
    output logic              disp_blank,
    output logic [CNT_W-1:0]  repeat_cnt
);

    sched_state_t      state, state_next;
    logic              accept;
    logic              frame_done;
    logic              read_go;
    logic              swap;
    logic              bump_repeat;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_at_last;
    logic              rd_at_last;

    assign accept     = host_valid & host_ready;
    assign frame_done = accept & (host_last | wr_at_last);
    assign read_go    = enable & disp_rd_req & ~disp_blank;

    fb_addr_counter #(.ADDR_W(ADDR_W), .LIMIT(FRAME_WORDS)) u_wr_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear   (~enable | frame_done),
        .inc     (accept),
        .count   (wr_ptr),
        .at_last (wr_at_last)
    );

    fb_addr_counter #(.ADDR_W(ADDR_W), .LIMIT(FRAME_WORDS)) u_rd_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear   (~enable | disp_frame_end),
        .inc     (read_go),
        .count   (rd_ptr),
        .at_last (rd_at_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        swap        = 1'b0;
        bump_repeat = 1'b0;
        host_ready  = enable & ((state == ST_FILL) | (state == ST_RUN));
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_FILL;
                ST_FILL, ST_RUN: begin
                    if (frame_done && disp_frame_end) begin
                        swap       = 1'b1;
                        state_next = ST_RUN;
                    end else if (frame_done) begin
                        state_next = ST_FULL;
                    end else if (disp_frame_end && state == ST_RUN) begin
                        bump_repeat = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (disp_frame_end) begin
                        swap       = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Writes target the back buffer (~front_sel), reads the front buffer, both
    // judged by front_sel before any swap on this edge, so they never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf0_we    <= 1'b0;
            buf1_we    <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            buf0_re    <= 1'b0;
            buf1_re    <= 1'b0;
            rd_addr    <= '0;
            front_sel  <= 1'b1;
            disp_blank <= 1'b1;
            repeat_cnt <= '0;
        end else begin
            buf0_we <= accept & front_sel;
            buf1_we <= accept & ~front_sel;
            if (accept) begin
                wr_addr <= wr_ptr;
                wr_data <= host_data;
            end
            buf0_re <= read_go & ~front_sel;
            buf1_re <= read_go & front_sel;
            if (read_go) begin
                rd_addr <= rd_ptr;
            end
            if (swap) begin
                front_sel <= ~front_sel;
            end
            if (!enable) begin
                disp_blank <= 1'b1;
            end else if (swap) begin
                disp_blank <= 1'b0;
            end
            if (bump_repeat && repeat_cnt != '1) begin
                repeat_cnt <= repeat_cnt + 1'b1;
            end
        end
    end

endmodule
